// File: rtl/mux_scan_controller.sv
// Round-robin scan sequencer for the 4-channel mux stage.
// Selects a channel, waits out the settle time, then hands the sample downstream.
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] ch_mask,
    input  logic [3:0] mux_out,
    output logic       sbit0,
    output logic       sbit1,
    output logic [3:0] sample_data,
    output logic [1:0] sample_ch,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_n;
    logic [1:0] sel;
    logic [1:0] last_ch;
    logic [1:0] nxt_ch;
    logic [1:0] cand;
    logic [3:0] cnt;
    logic       start;
    logic       capture;
    logic       done;
    logic       can_start;

    assign can_start = enable && (ch_mask != 4'd0);
    assign sbit0     = sel[0];
    assign sbit1     = sel[1];
    assign busy      = (state != IDLE);

    // Search from last_ch+1 with wrap; last_ch itself is checked last.
    always_comb begin
        nxt_ch = last_ch;
        cand   = last_ch;
        for (int i = 4; i >= 1; i--) begin
            cand = last_ch + 2'(i);
            if (ch_mask[cand]) begin
                nxt_ch = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_start) begin
                    start   = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (sample_valid && sample_ready) begin
                    done = 1'b1;
                    if (can_start) begin
                        start   = 1'b1;
                        state_n = SETTLE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Select, settle counter and sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= 2'd0;
            last_ch      <= 2'd3;
            cnt          <= 4'd0;
            sample_data  <= 4'd0;
            sample_ch    <= 2'd0;
            sample_valid <= 1'b0;
        end else begin
            if (start) begin
                sel <= nxt_ch;
                cnt <= CNT_LOAD;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                sample_data  <= mux_out;
                sample_ch    <= sel;
                last_ch      <= sel;
                sample_valid <= 1'b1;
            end else if (done) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
